// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM states, word-length codes, stop-bit
// lengths and the mode codes of the universal shift register.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam logic [1:0] WLS_5 = 2'b00;
  localparam logic [1:0] WLS_6 = 2'b01;
  localparam logic [1:0] WLS_7 = 2'b10;
  localparam logic [1:0] WLS_8 = 2'b11;

  // Stop lengths in ticks, quoted at 16x oversampling
  localparam int unsigned STOP_TICKS_1   = 16;
  localparam int unsigned STOP_TICKS_15  = 24;
  localparam int unsigned STOP_TICKS_2   = 32;
  localparam int unsigned STOP_TICKS_REF = 16;

  localparam logic [1:0] USR_HOLD = 2'b00;
  localparam logic [1:0] USR_SHR  = 2'b01;
  localparam logic [1:0] USR_SHL  = 2'b10;
  localparam logic [1:0] USR_LOAD = 2'b11;

  function automatic int unsigned data_bits(input logic [1:0] wls);
    case (wls)
      WLS_5:   return 5;
      WLS_6:   return 6;
      WLS_7:   return 7;
      WLS_8:   return 8;
      default: return 8;
    endcase
  endfunction

  // Stop length scaled to the configured oversampling rate
  function automatic int unsigned stop_ticks(input logic [1:0] wls, input logic stb,
                                             input int unsigned os);
    int unsigned t;
    if (!stb)             t = STOP_TICKS_1;
    else if (wls == WLS_5) t = STOP_TICKS_15;
    else                  t = STOP_TICKS_2;
    return (t * os) / STOP_TICKS_REF;
  endfunction

endpackage

// File: rtl/universal_shift_reg.sv
// Universal shift register: hold, shift right, shift left or parallel load.
module universal_shift_reg
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            mode,
  input  logic                  ser_in_r,
  input  logic                  ser_in_l,
  input  logic [DATA_WIDTH-1:0] par_in,
  output logic [DATA_WIDTH-1:0] par_out
);

  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] data_d;

  always_comb begin
    data_d = data_q;
    case (mode)
      USR_SHR:  data_d = {ser_in_r, data_q[DATA_WIDTH-1:1]};
      USR_SHL:  data_d = {data_q[DATA_WIDTH-2:0], ser_in_l};
      USR_LOAD: data_d = par_in;
      default:  data_d = data_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) data_q <= '0;
    else     data_q <= data_d;
  end

  assign par_out = data_q;

endmodule

// File: rtl/uart_transmitter_shift_block.sv
// UART transmit path: frames THR characters onto uart_txd at the 16x tick.
// Optional stick parity is compiled in with UART_TX_STICK_PARITY_EN.
module uart_transmitter_shift_block
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  pclk,
  input  logic                  rst,
  input  logic                  tx_tick,
  input  logic [DATA_WIDTH-1:0] thr_data,
  input  logic                  thr_valid,
  output logic                  thr_pop,
  input  logic [1:0]            wls,
  input  logic                  pen,
  input  logic                  eps,
  input  logic                  sp,
  input  logic                  stb,
  input  logic                  bc,
  input  logic                  loop,
  output logic                  uart_txd,
  output logic                  loop_txd,
  output logic                  tsr_empty,
  output logic                  tx_busy
);

  localparam int unsigned TICK_W = $clog2(2 * OVERSAMPLE);
  localparam int unsigned BIT_W  = $clog2(DATA_WIDTH);

  tx_state_t             state_q, state_d;
  logic [TICK_W-1:0]     tick_cnt_q, tick_cnt_d;
  logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [1:0]            wls_q, wls_d;
  logic                  pen_q, pen_d;
  logic                  stb_q, stb_d;
  logic                  par_q, par_d;
  logic                  uart_txd_q, uart_txd_d;
  logic                  loop_txd_q, loop_txd_d;
  logic                  thr_pop_q, thr_pop_d;
  logic                  tsr_empty_q, tsr_empty_d;
  logic                  tx_busy_q, tx_busy_d;

  logic [1:0]            tsr_mode_c;
  logic [DATA_WIDTH-1:0] tsr_c;
  logic                  load_c;
  logic                  bit_end_c;
  logic                  stop_end_c;
  logic [TICK_W-1:0]     stop_last_c;
  logic [DATA_WIDTH-1:0] data_masked_c;
  logic                  par_c;
  logic                  serial_c;
  logic                  line_c;
  logic                  tsr_unused;

  assign stop_last_c = TICK_W'(stop_ticks(wls_q, stb_q, OVERSAMPLE) - 1);
  assign bit_end_c   = tx_tick && (tick_cnt_q == TICK_W'(OVERSAMPLE - 1));
  assign stop_end_c  = tx_tick && (tick_cnt_q == stop_last_c);

  // Parity covers only the characters' valid bits, captured at load time
  assign data_masked_c = thr_data & ~({DATA_WIDTH{1'b1}} << data_bits(wls));
`ifdef UART_TX_STICK_PARITY_EN
  assign par_c = sp ? ~eps : ((^data_masked_c) ^ ~eps);
`else
  logic sp_unused;
  assign sp_unused = sp;
  assign par_c     = (^data_masked_c) ^ ~eps;
`endif

  universal_shift_reg #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_tsr (
    .clk     (pclk),
    .rst     (rst),
    .mode    (tsr_mode_c),
    .ser_in_r(1'b0),
    .ser_in_l(1'b0),
    .par_in  (thr_data),
    .par_out (tsr_c)
  );

  assign tsr_unused = ^tsr_c[DATA_WIDTH-1:1];

  // State and output registers
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      tick_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      wls_q       <= WLS_8;
      pen_q       <= 1'b0;
      stb_q       <= 1'b0;
      par_q       <= 1'b0;
      uart_txd_q  <= 1'b1;
      loop_txd_q  <= 1'b1;
      thr_pop_q   <= 1'b0;
      tsr_empty_q <= 1'b1;
      tx_busy_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      wls_q       <= wls_d;
      pen_q       <= pen_d;
      stb_q       <= stb_d;
      par_q       <= par_d;
      uart_txd_q  <= uart_txd_d;
      loop_txd_q  <= loop_txd_d;
      thr_pop_q   <= thr_pop_d;
      tsr_empty_q <= tsr_empty_d;
      tx_busy_q   <= tx_busy_d;
    end
  end

  // Frame sequencing, bit timing and TSR control
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    wls_d      = wls_q;
    pen_d      = pen_q;
    stb_d      = stb_q;
    par_d      = par_q;
    tsr_mode_c = USR_HOLD;
    load_c     = 1'b0;

    if (state_q != IDLE && tx_tick) tick_cnt_d = tick_cnt_q + TICK_W'(1);

    case (state_q)
      IDLE: begin
        if (thr_valid) load_c = 1'b1;
      end
      START: begin
        if (bit_end_c) begin
          state_d    = DATA;
          tick_cnt_d = '0;
          bit_cnt_d  = '0;
        end
      end
      DATA: begin
        if (bit_end_c) begin
          tick_cnt_d = '0;
          tsr_mode_c = USR_SHR;
          if (bit_cnt_q == BIT_W'(data_bits(wls_q) - 1)) state_d = pen_q ? PARITY : STOP;
          else bit_cnt_d = bit_cnt_q + BIT_W'(1);
        end
      end
      PARITY: begin
        if (bit_end_c) begin
          state_d    = STOP;
          tick_cnt_d = '0;
        end
      end
      STOP: begin
        if (stop_end_c) begin
          tick_cnt_d = '0;
          if (thr_valid) load_c  = 1'b1;
          else           state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Loading restarts the frame whether it comes from IDLE or a finished STOP
    if (load_c) begin
      state_d    = START;
      tick_cnt_d = '0;
      bit_cnt_d  = '0;
      tsr_mode_c = USR_LOAD;
      wls_d      = wls;
      pen_d      = pen;
      stb_d      = stb;
      par_d      = par_c;
    end
  end

  // Line value, break/loopback routing and status
  always_comb begin
    serial_c = 1'b1;
    case (state_q)
      START:   serial_c = 1'b0;
      DATA:    serial_c = tsr_c[0];
      PARITY:  serial_c = par_q;
      default: serial_c = 1'b1;
    endcase
    line_c      = serial_c & ~bc;
    uart_txd_d  = loop ? 1'b1 : line_c;
    loop_txd_d  = loop ? line_c : 1'b1;
    thr_pop_d   = load_c;
    tsr_empty_d = (state_d == IDLE);
    tx_busy_d   = (state_d != IDLE);
  end

  assign uart_txd  = uart_txd_q;
  assign loop_txd  = loop_txd_q;
  assign thr_pop   = thr_pop_q;
  assign tsr_empty = tsr_empty_q;
  assign tx_busy   = tx_busy_q;

endmodule

// File: doc/uart_transmitter_shift_block.md
Name: uart_transmitter_shift_block

Overview:
- Serialises one character from the Transmit Holding Register (THR) into a UART frame on uart_txd: start bit, 5-8 data bits (LSB first), optional parity, then 1, 1.5 or 2 stop bits.
- Paced by a 16x baud tick from the shared baud generator.
- Sits beside uart_receiver_shift_block and drives its loop_txd input when loopback is active.
- Owns the Transmit Shift Register (TSR), bit-phase counter and frame FSM.

Parameters:
- OVERSAMPLE, 16, tx_tick pulses per bit period (power of 2, minimum 8).
- DATA_WIDTH, 8, maximum character width.

Ports:
- pclk  in  1  UART clock.
- rst  in  1  Reset, asynchronous, active-high.
- tx_tick  in  1  One-pclk 16x baud strobe.
- thr_data  in  8  THR contents.
- thr_valid  in  1  THR holds a character.
- thr_pop  out  1  One-cycle pulse: TSR loaded from THR this cycle.
- wls  in  2  Word length select: 00=5 … 11=8 bits.
- pen  in  1  Parity enable.
- eps  in  1  Even parity select.
- sp  in  1  Stick parity.
- stb  in  1  0: 1 stop bit; 1: 2 stop bits (1.5 stop bits when wls=00).
- bc  in  1  Break control.
- loop  in  1  Loopback mode.
- uart_txd  out  1  Serial line output, registered.
- loop_txd  out  1  Serial stream routed to the receiver in loopback.
- tsr_empty  out  1  High when the TSR is idle and nothing is in flight (LSR TEMT).
- tx_busy  out  1  High while the FSM is not IDLE.

Behaviour:
- Reset values: uart_txd=1, loop_txd=1, thr_pop=0, tsr_empty=1, tx_busy=0, FSM=IDLE, tick_cnt=0, bit_cnt=0.
- Reset is honoured mid-frame: the line returns to 1 immediately, FSM goes to IDLE and the partial frame is discarded.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - If thr_valid=1, assert thr_pop for one cycle, latch thr_data into the TSR, latch wls/pen/eps/sp/stb into frame registers, clear tick_cnt and go to START.
  - Configuration changes mid-frame do not affect the frame in flight.
- Bit timing:
  - tick_cnt increments on each tx_tick.
  - A bit ends on the tx_tick where tick_cnt = OVERSAMPLE-1.
  - Each bit spans exactly OVERSAMPLE ticks; the line changes only at a bit boundary.
- START: line=0 for one bit, then DATA with bit_cnt=0.
- DATA:
  - line = TSR[0]; the TSR shifts right at each bit end.
  - After wls+5 bits: go to PARITY if pen=1, otherwise STOP.
- PARITY:
  - sp=0: bit = (^data) XOR ~eps, i.e. even when eps=1, odd when eps=0.
  - sp=1: bit = ~eps.
  - Parity covers only the wls+5 valid bits.
- STOP:
  - line=1.
  - Duration: 16 ticks if stb=0; 32 ticks if stb=1 and wls≠00; 24 ticks if stb=1 and wls=00.
- End of STOP:
  - If thr_valid=1, pop and go directly to START in the same cycle, with no idle gap.
  - Otherwise go to IDLE; tsr_empty rises the following cycle.
- tx_tick is ignored in IDLE. Start-bit timing begins at the first tx_tick after the load.
- Break (bc=1):
  - serial value is forced to 0 while the FSM continues normally.
  - On release, the line resumes the current FSM value at the next pclk.
- Loopback (loop=1): uart_txd=1 and loop_txd carries the serial value. With loop=0, loop_txd=1.
- Simultaneous thr_valid and rst: rst wins; no pop occurs.

Optional Feature:
- Macro: UART_TX_STICK_PARITY_EN.
- Defined: sp behaves as described above.
- Undefined: the sp input is ignored and parity is always computed from eps; sp logic is not synthesised.

Decomposition:
- Shared package uart_pkg:
  - state encoding tx_state_t {IDLE, START, DATA, PARITY, STOP};
  - constants for wls codes;
  - STOP_TICKS_1 = 16, STOP_TICKS_15 = 24, STOP_TICKS_2 = 32.
- One natural sub-module: the existing universal_shift_reg, instantiated with DATA_WIDTH = 8 as the TSR, using parallel load and shift-right modes. The FSM and counters stay in this block.

Test Plan:
- wls=11, pen=0, stb=0, thr_data=8'hA5 -> uart_txd is 0,1,0,1,0,0,1,0,1,1, each bit 16 ticks; one thr_pop; tsr_empty=1 after STOP.
- wls=00, pen=1, eps=1, stb=1, data=5'b10110 -> start, 0,1,1,0,1, parity=1, stop lasts 24 ticks.
- Two characters back-to-back with thr_valid held -> second start bit directly follows the 16th stop tick; exactly two thr_pop pulses; tx_busy never drops.
- Assert bc mid-DATA for 20 ticks -> uart_txd=0 throughout; bit_cnt still advances; the frame finishes on schedule.
- loop=1, data=8'h3C -> uart_txd constant 1; loop_txd carries the full frame.
- rst pulsed during PARITY -> uart_txd=1 and tsr_empty=1 immediately; the next thr_valid starts a clean frame.
